// File: rtl/osc_div.sv
// Multi-channel counter-based clock-pattern generator: per-channel programmable
// period, high time and enable, with config changes applied at period boundaries.
module osc_div #(
  parameter  int CH = 4,
  parameter  int W  = 16,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic [W-1:0]  cfg_high,
  input  logic          cfg_en,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] pend
);

  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};

  // A divider of zero would give a one-cycle period; force the minimum period of two.
  function automatic logic [W-1:0] fix_div(input logic [W-1:0] d);
    return (d == ZERO_W) ? ONE_W : d;
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt_r, div_a_r, high_a_r, div_sh_r, high_sh_r;
    logic         en_a_r, en_sh_r, pend_r, clk_r, tick_r;
    logic [W-1:0] cnt_s, div_a_s, high_a_s, div_sh_s, high_sh_s;
    logic         en_a_s, en_sh_s, pend_s, clk_s, tick_s, hit_s, wrap_s;

    // Next-state: direct load when idle, staged load when running, swap at the wrap edge.
    always_comb begin
      hit_s     = cfg_wr && ({{(32-CW){1'b0}}, cfg_ch} == 32'(i));
      wrap_s    = en_a_r && (cnt_r == div_a_r);
      cnt_s     = cnt_r;
      div_a_s   = div_a_r;
      high_a_s  = high_a_r;
      en_a_s    = en_a_r;
      div_sh_s  = div_sh_r;
      high_sh_s = high_sh_r;
      en_sh_s   = en_sh_r;
      pend_s    = pend_r;
      clk_s     = 1'b0;
      tick_s    = 1'b0;
      if (!en_a_r) begin
        cnt_s = ZERO_W;
        if (hit_s) begin
          div_a_s   = fix_div(cfg_div);
          high_a_s  = cfg_high;
          en_a_s    = cfg_en;
          div_sh_s  = fix_div(cfg_div);
          high_sh_s = cfg_high;
          en_sh_s   = cfg_en;
          pend_s    = 1'b0;
        end else begin
          pend_s = 1'b0;
        end
      end else if (wrap_s) begin
        cnt_s  = ZERO_W;
        pend_s = 1'b0;
        // A write landing on the wrap cycle bypasses the shadow entirely.
        if (hit_s) begin
          div_a_s   = fix_div(cfg_div);
          high_a_s  = cfg_high;
          en_a_s    = cfg_en;
          div_sh_s  = fix_div(cfg_div);
          high_sh_s = cfg_high;
          en_sh_s   = cfg_en;
        end else if (pend_r) begin
          div_a_s  = div_sh_r;
          high_a_s = high_sh_r;
          en_a_s   = en_sh_r;
        end else begin
          en_a_s = en_a_r;
        end
      end else begin
        cnt_s = cnt_r + ONE_W;
        if (hit_s) begin
          div_sh_s  = fix_div(cfg_div);
          high_sh_s = cfg_high;
          en_sh_s   = cfg_en;
          pend_s    = 1'b1;
        end else begin
          pend_s = pend_r;
        end
      end
      if (en_a_s) begin
        clk_s  = (cnt_s < high_a_s);
        tick_s = (cnt_s == ZERO_W);
      end else begin
        cnt_s  = ZERO_W;
        clk_s  = 1'b0;
        tick_s = 1'b0;
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r     <= ZERO_W;
        div_a_r   <= ONE_W;
        high_a_r  <= ONE_W;
        en_a_r    <= 1'b0;
        div_sh_r  <= ONE_W;
        high_sh_r <= ONE_W;
        en_sh_r   <= 1'b0;
        pend_r    <= 1'b0;
        clk_r     <= 1'b0;
        tick_r    <= 1'b0;
      end else begin
        cnt_r     <= cnt_s;
        div_a_r   <= div_a_s;
        high_a_r  <= high_a_s;
        en_a_r    <= en_a_s;
        div_sh_r  <= div_sh_s;
        high_sh_r <= high_sh_s;
        en_sh_r   <= en_sh_s;
        pend_r    <= pend_s;
        clk_r     <= clk_s;
        tick_r    <= tick_s;
      end
    end

    assign clk_out[i] = clk_r;
    assign tick[i]    = tick_r;
    assign pend[i]    = pend_r;
  end

endmodule

// File: tb/tb_osc_div.sv
// Scoreboarded random/directed bench for osc_div against a period/phase reference model.
module tb_osc_div;
  localparam int CH = 5;
  localparam int W  = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [W-1:0]  cfg_high = '0;
  logic          cfg_en = 1'b0;
  logic [CH-1:0] clk_out, tick, pend;

  osc_div #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_high(cfg_high), .cfg_en(cfg_en), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] c;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each channel is a period length, a high time and a phase
  // within the current period; staged configs wait for the last phase.
  int m_en[CH], m_p[CH], m_h[CH], m_ph[CH], m_stg[CH];
  int s_en[CH], s_p[CH], s_h[CH];

  function automatic int period_of(input logic [W-1:0] d);
    return (d == 16'd0) ? 2 : int'(d) + 1;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < CH; i++) begin
      bit hit;
      hit = cfg_wr && (int'(cfg_ch) == i);
      if (rst) begin
        m_en[i] = 0; m_p[i] = 2; m_h[i] = 1; m_ph[i] = 0; m_stg[i] = 0;
      end else if (m_en[i] == 0) begin
        if (hit) begin
          m_en[i] = int'(cfg_en); m_p[i] = period_of(cfg_div); m_h[i] = int'(cfg_high);
        end
        m_ph[i] = 0;
      end else if (m_ph[i] == m_p[i] - 1) begin
        m_ph[i] = 0;
        if (hit) begin
          m_en[i] = int'(cfg_en); m_p[i] = period_of(cfg_div); m_h[i] = int'(cfg_high);
        end else if (m_stg[i] != 0) begin
          m_en[i] = s_en[i]; m_p[i] = s_p[i]; m_h[i] = s_h[i];
        end
        m_stg[i] = 0;
      end else begin
        m_ph[i] = m_ph[i] + 1;
        if (hit) begin
          s_en[i] = int'(cfg_en); s_p[i] = period_of(cfg_div); s_h[i] = int'(cfg_high);
          m_stg[i] = 1;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      e.c[i] = (m_en[i] != 0) && (m_ph[i] < m_h[i]);
      e.t[i] = (m_en[i] != 0) && (m_ph[i] == 0);
      e.p[i] = (m_stg[i] != 0);
    end
    return e;
  endfunction

  // One cycle of stimulus; the expected outputs after the next edge are queued.
  task automatic cyc(input bit r, input bit w, input int ch, input int d, input int h, input bit e);
    @(negedge clk);
    rst = r; cfg_wr = w; cfg_ch = ch[CW-1:0]; cfg_div = d[W-1:0]; cfg_high = h[W-1:0]; cfg_en = e;
    model_step();
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch, input int d, input int h, input bit e);
    cyc(1'b0, 1'b1, ch, d, h, e);
  endtask

  // Idle until the model says channel ch sits at phase ph in the coming cycle.
  task automatic wait_phase(input int ch, input int ph);
    int n;
    n = 0;
    while (m_ph[ch] != ph && n < 70000) begin
      idle(1);
      n++;
    end
    if (m_ph[ch] != ph) begin
      errors++;
      $display("FAIL wait_phase ch=%0d got phase=%0d want %0d (timeout)", ch, m_ph[ch], ph);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (clk_out !== e.c || tick !== e.t || pend !== e.p) begin
          errors++;
          $display("FAIL outputs t=%0t got clk_out=%b tick=%b pend=%b want clk_out=%b tick=%b pend=%b",
                   $time, clk_out, tick, pend, e.c, e.t, e.p);
        end
      end
    end
  end

  initial begin
    int pick;
    int ch;
    repeat (3) cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(2);
    // Basic pattern on ch0: 1,1,0,0 with a tick every four cycles.
    wr(0, 3, 2, 1'b1);
    idle(12);
    // Staged reconfiguration of a running channel.
    wr(1, 9, 5, 1'b1);
    wait_phase(1, 3);
    wr(1, 1, 1, 1'b1);
    idle(14);
    // Bypass at the wrap cycle, then two writes while pending.
    wait_phase(1, m_p[1] - 1);
    wr(1, 4, 3, 1'b1);
    idle(3);
    wait_phase(1, 1);
    wr(1, 2, 1, 1'b1);
    idle(1);
    wr(1, 6, 2, 1'b1);
    idle(20);
    // Boundary high/div values on ch2, each loaded at a period boundary.
    wr(2, 2, 0, 1'b1);
    idle(8);
    wr(2, 2, 3, 1'b1);
    idle(8);
    wr(2, 2, 65535, 1'b1);
    idle(8);
    wr(2, 0, 1, 1'b1);
    idle(8);
    // Staged disable, then re-enable.
    wr(2, 5, 3, 1'b1);
    idle(10);
    wait_phase(2, 2);
    wr(2, 5, 3, 1'b0);
    idle(12);
    wr(2, 5, 3, 1'b1);
    idle(8);
    // Reset with a pending config and a same-cycle write.
    wait_phase(0, 1);
    wr(0, 7, 4, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 0, 2, 1, 1'b1);
    idle(5);
    // Out-of-range channel writes.
    wr(5, 2, 1, 1'b1);
    wr(6, 2, 1, 1'b1);
    wr(7, 2, 1, 1'b1);
    idle(5);
    // Full-width period on ch4 while random traffic hits the other channels.
    wr(4, 65535, 32768, 1'b1);
    for (int k = 0; k < 65600; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        pick = int'($urandom_range(0, 6));
        ch = (pick < 4) ? pick : pick + 1;
        wr(ch, int'($urandom_range(0, 12)), int'($urandom_range(0, 15)), $urandom_range(0, 5) != 0);
      end else begin
        idle(1);
      end
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osc_div.md
# osc_div

Synthesisable, parametrised multi-channel clock-pattern generator, the successor to the behavioural self-triggering oscillator. It replaces the delay-driven oscillator with counter-based outputs derived from the single system clock. Each channel has a programmable period, high time and enable. Configuration changes are applied glitch-free at period boundaries. It drives divided-clock enables and strobes to downstream logic.

## Interface
- CH, 4, number of independent channels (1..16)
- W, 16, counter and configuration width in bits
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_wr  in  1  configuration write strobe, one cycle per write
- cfg_ch  in  clog2(CH) (min 1)  target channel; values >= CH ignore the write
- cfg_div  in  W  period minus one; period P = cfg_div+1; 0 treated as 1 (P=2)
- cfg_high  in  W  high time in cycles; 0 = constant low, >= P = constant high
- cfg_en  in  1  channel enable
- clk_out  out  CH  per-channel registered pattern output
- tick  out  CH  per-channel one-cycle strobe at period start
- pend  out  CH  per-channel flag: staged config not yet applied

## Operation
- Per-channel state: active regs (div_a, high_a, en_a), shadow regs (div_s, high_s, en_s), counter cnt[W-1:0].
- Reset values: cnt=0, div_a=1, high_a=1, en_a=0, shadow = active, clk_out=0, tick=0, pend=0.
- Running channel (en_a=1):
  - cnt counts 0..div_a and then wraps to 0.
  - clk_out = (cnt < high_a).
  - tick = (cnt == 0).
  - clk_out and tick are both registers aligned with cnt.
- Disabled channel (en_a=0): cnt, clk_out and tick held at 0.
- Write to a disabled channel: active regs load directly at the next edge; pend stays 0.
- Write to a running channel:
  - The values are staged into shadow and pend is set the next cycle.
  - The wrap cycle is the cycle with cnt == div_a. At its edge the shadow is copied to active, pend clears and cnt goes to 0.
- Write coinciding with the wrap cycle: the write data bypasses the shadow and is applied at that same edge; pend stays 0.
- Second write while pend=1: overwrites the shadow; only the last write takes effect.
- Disable (cfg_en=0) on a running channel is staged, so the output stops only at a period boundary: after the last full period, clk_out=0 from the boundary onward.
- Writes to different channels are independent. There is one write per cycle, so no arbitration is needed.
- Arithmetic:
  - The comparison cnt < high_a is unsigned W-bit.
  - With cfg_div = 2^W-1, the period is 2^W and cnt wraps naturally.
  - The div=0 to 1 substitution is applied when the value is loaded into the active regs.

## Timing
- Write latency:
  - Disabled channel: the write lands at cycle t. At t+1 the first period starts: cnt=0, tick=1, clk_out=(high>0).
  - Running channel: the new period starts the cycle after the wrap cycle.
- tick is high for exactly one cycle per period.
- Outputs contain no combinational paths from inputs.
- clk_out toggles only on clk edges and has no glitches.
- Reset mid-period: at the edge where rst=1, all state returns to reset values, including shadow and pend. Pending configs are discarded.
- rst takes priority over a same-cycle cfg_wr.

## Test plan
- Reset, then write ch0 {div=3, high=2, en=1} at cycle 5 → from cycle 6 clk_out[0] = 1,1,0,0 repeating; tick[0] at cycles 6,10,14; other channels stay 0.
- Ch1 running {div=9, high=5}; write {div=1, high=1} at cnt=3 → pend[1]=1 from the next cycle until the wrap; the old 10-cycle period completes, then the pattern is 1,0 repeating; pend[1]=0 after the wrap.
- Write at exactly cnt==div_a (bypass) → the new config starts the next cycle and pend never asserts; then two writes while pend=1 → only the second takes effect.
- Boundary configs: high=0 → constant 0 with ticks present; high=P and high=0xFFFF → constant 1; div=0 → period 2; div=0xFFFF with W=16 → period 65536 and a single tick per period.
- Disable ch2 mid-period → the output finishes the current period, then stays 0 with no further ticks; re-enable → restarts at cnt=0 with tick.
- rst asserted mid-period with pend=1 and a same-cycle cfg_wr → all outputs 0 at the next cycle; no config survives; cfg_ch >= CH writes are ignored.
